// File: rtl/i2cmb_wb_seq.sv
// Wishbone-master sequencer for the I2CMB controller: turns one-byte I2C
// read/write requests into the CSR/DPR/CMDR access and CMDR-polling sequence.
module i2cmb_wb_seq #(
  parameter int unsigned POLL_LIMIT = 4096
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_rw_i,
  input  logic [6:0] req_addr_i,
  input  logic [7:0] req_data_i,
  input  logic [3:0] req_bus_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic [1:0] rsp_status_o,
  output logic       cyc_o,
  output logic       stb_o,
  output logic       we_o,
  output logic [1:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i
);

  localparam int unsigned PW = $clog2(POLL_LIMIT + 1);

  localparam logic [1:0] ADR_CSR  = 2'd0;
  localparam logic [1:0] ADR_DPR  = 2'd1;
  localparam logic [1:0] ADR_CMDR = 2'd2;

  localparam logic [7:0] CMD_WRITE    = 8'h01;
  localparam logic [7:0] CMD_READ_NAK = 8'h03;
  localparam logic [7:0] CMD_START    = 8'h04;
  localparam logic [7:0] CMD_STOP     = 8'h05;
  localparam logic [7:0] CMD_SET_BUS  = 8'h06;
  localparam logic [7:0] CSR_ENABLE   = 8'h80;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_NAK = 2'b01;
  localparam logic [1:0] ST_AL  = 2'b10;
  localparam logic [1:0] ST_ERR = 2'b11;

  typedef enum logic [4:0] {
    IDLE, CSR_W,
    BUS_DPR, BUS_CMD, BUS_WAIT,
    START_CMD, START_WAIT,
    ADDR_DPR, ADDR_CMD, ADDR_WAIT,
    DATA_DPR, DATA_CMD, DATA_WAIT,
    READ_CMD, READ_WAIT, READ_DPR,
    STOP_CMD, STOP_WAIT,
    RESP
  } state_t;

  state_t         state, state_n;
  logic           en, en_n;
  logic           rw, rw_n;
  logic [6:0]     addr, addr_n;
  logic [7:0]     data, data_n;
  logic [3:0]     bus, bus_n;
  logic [1:0]     stat, stat_n;
  logic [7:0]     rd, rd_n;
  logic [PW-1:0]  poll, poll_n;

  logic           cyc_n, stb_n, we_n;
  logic [1:0]     adr_n;
  logic [7:0]     dat_n;
  logic           ready_n, rsp_valid_n;
  logic [7:0]     rsp_data_n;
  logic [1:0]     rsp_status_n;

  logic           acc_we;
  logic [1:0]     acc_adr;
  logic [7:0]     acc_dat;
  logic           is_wait;
  state_t         step_next;

  logic           f_don, f_nak, f_al, f_err, poll_last;
  logic [1:0]     fail_code;

  assign f_don     = dat_i[7];
  assign f_nak     = dat_i[6];
  assign f_al      = dat_i[5];
  assign f_err     = dat_i[4];
  assign fail_code = f_al ? ST_AL : (f_err ? ST_ERR : ST_NAK);
  assign poll_last = (poll == PW'(POLL_LIMIT - 1));

  // Per-state Wishbone access and the state that follows a successful access
  always_comb begin
    acc_we    = 1'b1;
    acc_adr   = ADR_CMDR;
    acc_dat   = 8'h00;
    is_wait   = 1'b0;
    step_next = IDLE;
    case (state)
      CSR_W:      begin acc_adr = ADR_CSR; acc_dat = CSR_ENABLE; step_next = BUS_DPR; end
      BUS_DPR:    begin acc_adr = ADR_DPR; acc_dat = {4'h0, bus}; step_next = BUS_CMD; end
      BUS_CMD:    begin acc_dat = CMD_SET_BUS;  step_next = BUS_WAIT; end
      BUS_WAIT:   begin acc_we = 1'b0; is_wait = 1'b1; step_next = START_CMD; end
      START_CMD:  begin acc_dat = CMD_START;    step_next = START_WAIT; end
      START_WAIT: begin acc_we = 1'b0; is_wait = 1'b1; step_next = ADDR_DPR; end
      ADDR_DPR:   begin acc_adr = ADR_DPR; acc_dat = {addr, rw}; step_next = ADDR_CMD; end
      ADDR_CMD:   begin acc_dat = CMD_WRITE;    step_next = ADDR_WAIT; end
      ADDR_WAIT:  begin acc_we = 1'b0; is_wait = 1'b1; step_next = rw ? READ_CMD : DATA_DPR; end
      DATA_DPR:   begin acc_adr = ADR_DPR; acc_dat = data; step_next = DATA_CMD; end
      DATA_CMD:   begin acc_dat = CMD_WRITE;    step_next = DATA_WAIT; end
      DATA_WAIT:  begin acc_we = 1'b0; is_wait = 1'b1; step_next = STOP_CMD; end
      READ_CMD:   begin acc_dat = CMD_READ_NAK; step_next = READ_WAIT; end
      READ_WAIT:  begin acc_we = 1'b0; is_wait = 1'b1; step_next = READ_DPR; end
      READ_DPR:   begin acc_we = 1'b0; acc_adr = ADR_DPR; step_next = STOP_CMD; end
      STOP_CMD:   begin acc_dat = CMD_STOP;     step_next = STOP_WAIT; end
      STOP_WAIT:  begin acc_we = 1'b0; is_wait = 1'b1; step_next = RESP; end
      default:    ;
    endcase
  end

  // Next state, Wishbone handshake and response capture
  always_comb begin
    state_n      = state;
    en_n         = en;
    rw_n         = rw;
    addr_n       = addr;
    data_n       = data;
    bus_n        = bus;
    stat_n       = stat;
    rd_n         = rd;
    poll_n       = '0;
    cyc_n        = cyc_o;
    stb_n        = stb_o;
    we_n         = we_o;
    adr_n        = adr_o;
    dat_n        = dat_o;
    rsp_data_n   = rsp_data_o;
    rsp_status_n = rsp_status_o;

    // An access starts only from cyc low, so a dropped cycle always idles one clock
    if (state != IDLE && state != RESP) begin
      if (!cyc_o) begin
        cyc_n = 1'b1;
        stb_n = 1'b1;
        we_n  = acc_we;
        adr_n = acc_adr;
        dat_n = acc_dat;
      end else if (ack_i) begin
        cyc_n = 1'b0;
        stb_n = 1'b0;
      end
    end

    if (is_wait) poll_n = poll;

    case (state)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          rw_n    = req_rw_i;
          addr_n  = req_addr_i;
          data_n  = req_data_i;
          bus_n   = req_bus_i;
          stat_n  = ST_OK;
          rd_n    = 8'h00;
          state_n = en ? BUS_DPR : CSR_W;
        end
      end
      RESP: state_n = IDLE;
      default: begin
        if (cyc_o && ack_i) begin
          if (is_wait) begin
            poll_n = poll + PW'(1);
            if (state == STOP_WAIT) begin
              if (f_al || f_err || f_nak) begin
                stat_n  = (stat != ST_OK) ? stat : fail_code;
                state_n = RESP;
              end else if (f_don) begin
                state_n = RESP;
              end else if (poll_last) begin
                stat_n  = ST_ERR;
                state_n = RESP;
              end
            end else if (f_al || f_err) begin
              stat_n  = fail_code;
              state_n = RESP;
            end else if (f_nak && (state == ADDR_WAIT || state == DATA_WAIT)) begin
              stat_n  = ST_NAK;
              state_n = STOP_CMD;
            end else if (f_don || f_nak) begin
              state_n = step_next;
            end else if (poll_last) begin
              stat_n  = ST_ERR;
              state_n = RESP;
            end
          end else begin
            if (state == CSR_W) en_n = 1'b1;
            if (state == READ_DPR) rd_n = dat_i;
            state_n = step_next;
          end
        end
      end
    endcase

    ready_n     = (state_n == IDLE);
    rsp_valid_n = (state_n == RESP);
    if (state_n == RESP) begin
      rsp_data_n   = rd_n;
      rsp_status_n = stat_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      en           <= 1'b0;
      rw           <= 1'b0;
      addr         <= 7'h00;
      data         <= 8'h00;
      bus          <= 4'h0;
      stat         <= ST_OK;
      rd           <= 8'h00;
      poll         <= '0;
      cyc_o        <= 1'b0;
      stb_o        <= 1'b0;
      we_o         <= 1'b0;
      adr_o        <= 2'd0;
      dat_o        <= 8'h00;
      req_ready_o  <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_data_o   <= 8'h00;
      rsp_status_o <= ST_OK;
    end else begin
      state        <= state_n;
      en           <= en_n;
      rw           <= rw_n;
      addr         <= addr_n;
      data         <= data_n;
      bus          <= bus_n;
      stat         <= stat_n;
      rd           <= rd_n;
      poll         <= poll_n;
      cyc_o        <= cyc_n;
      stb_o        <= stb_n;
      we_o         <= we_n;
      adr_o        <= adr_n;
      dat_o        <= dat_n;
      req_ready_o  <= ready_n;
      rsp_valid_o  <= rsp_valid_n;
      rsp_data_o   <= rsp_data_n;
      rsp_status_o <= rsp_status_n;
    end
  end

endmodule

// File: tb/tb_i2cmb_wb_seq.sv
// Directed bench for i2cmb_wb_seq with a behavioural I2CMB register-level slave.
module tb_i2cmb_wb_seq;

  localparam logic [6:0] ABSENT     = 7'h10;
  localparam logic [7:0] SLAVE_BYTE = 8'h5C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [6:0] req_addr = 7'h00;
  logic [7:0] req_data = 8'h00;
  logic [3:0] req_bus = 4'h0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [1:0] rsp_status;
  logic       cyc, stb, we;
  logic [1:0] adr;
  logic [7:0] wdat;
  logic [7:0] rdat = 8'h00;
  logic       ack = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  i2cmb_wb_seq #(.POLL_LIMIT(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rw_i(req_rw),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_bus_i(req_bus),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_status_o(rsp_status),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(wdat),
    .dat_i(rdat), .ack_i(ack)
  );

  // Slave: registered ack, one busy poll per command, NAK for ABSENT address
  logic [9:0] wlog[$];
  int         cmdr_reads = 0;
  int         dpr_reads = 0;
  int         fsmr_hits = 0;
  int         busy_left = 0;
  logic [7:0] seen_data = 8'h00;
  logic [7:0] dpr_w = 8'h00;
  logic [7:0] dpr_r = 8'h00;
  logic [2:0] last_cmd = 3'b000;
  logic       after_start = 1'b0;
  logic       nak_pend = 1'b0;
  logic       hang_start = 1'b0;

  always @(posedge clk) begin
    if (!cyc || ack) ack <= 1'b0;
    else if (stb) begin
      ack <= 1'b1;
      if (adr == 2'd3) fsmr_hits++;
      if (we) begin
        wlog.push_back({adr, wdat});
        if (adr == 2'd1) dpr_w = wdat;
        else if (adr == 2'd2) begin
          last_cmd   = wdat[2:0];
          busy_left  = 1;
          nak_pend   = 1'b0;
          cmdr_reads = 0;
          case (wdat[2:0])
            3'b100: after_start = 1'b1;
            3'b001: begin
              if (after_start) nak_pend = (dpr_w[7:1] == ABSENT);
              else seen_data = dpr_w;
              after_start = 1'b0;
            end
            3'b011: dpr_r = SLAVE_BYTE;
            default: ;
          endcase
        end
      end else if (adr == 2'd2) begin
        cmdr_reads++;
        if (hang_start && last_cmd == 3'b100) rdat <= 8'h00;
        else if (busy_left > 0) begin busy_left--; rdat <= 8'h00; end
        else rdat <= nak_pend ? 8'h40 : 8'h80;
      end else if (adr == 2'd1) begin
        dpr_reads++;
        rdat <= dpr_r;
      end else rdat <= 8'h00;
    end
  end

  // Bus-protocol and response-pulse monitor
  int         proto_err = 0;
  int         rsp_count = 0;
  logic       p_cyc = 1'b0, p_ack = 1'b0, p_rsp = 1'b0;
  logic [10:0] p_bus = '0;
  always @(posedge clk) begin
    if (rst_n) begin
      if (cyc !== stb) proto_err++;
      if (p_cyc && p_ack && cyc) proto_err++;
      if (p_cyc && !p_ack && cyc && ({adr, we, wdat} !== p_bus)) proto_err++;
      if (p_rsp && rsp_valid) proto_err++;
      if (rsp_valid) rsp_count++;
    end
    p_cyc = cyc; p_ack = ack; p_rsp = rsp_valid; p_bus = {adr, we, wdat};
  end

  function automatic int log_diff(input int mark, input logic [9:0] e[$]);
    int bad = 0;
    if (wlog.size() - mark != e.size()) return -1;
    foreach (e[i]) if (wlog[mark + i] !== e[i]) bad++;
    return bad;
  endfunction

  task automatic wait_rsp(input string name);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    tests++;
    if (rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_rsp_timeout: rsp_valid=%b after %0d cycles, required 1", name, rsp_valid, n);
    end
  endtask

  task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d, input logic [3:0] b);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_data = d; req_bus = b;
    while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({cyc, stb, we, adr, wdat, req_ready, rsp_valid, rsp_data, rsp_status} !== 24'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, required 000000",
               {cyc, stb, we, adr, wdat, req_ready, rsp_valid, rsp_data, rsp_status});
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b, required 1", req_ready); end
  endtask

  task automatic test_write();
    int mark = wlog.size();
    int d;
    logic [9:0] e[$];
    send(1'b0, 7'h22, 8'hA5, 4'h0);
    wait_rsp("write");
    e = '{10'h080, 10'h100, 10'h206, 10'h204, 10'h144, 10'h201, 10'h1A5, 10'h201, 10'h205};
    d = log_diff(mark, e);
    tests++;
    if (d != 0) begin fails++; $display("FAIL write_seq: %0d writes, diff %0d, required 9 writes diff 0", wlog.size() - mark, d); end
    tests++;
    if (seen_data !== 8'hA5) begin fails++; $display("FAIL write_slave_data: got %h, required a5", seen_data); end
    tests++;
    if ({rsp_status, rsp_data} !== 10'h000) begin fails++; $display("FAIL write_rsp: status %b data %h, required 00 00", rsp_status, rsp_data); end
    @(negedge clk);
    tests++;
    if ({rsp_valid, req_ready} !== 2'b01) begin fails++; $display("FAIL write_pulse_idle: valid/ready %b, required 01", {rsp_valid, req_ready}); end
  endtask

  task automatic test_read();
    int mark = wlog.size();
    int dr = dpr_reads;
    int d;
    logic [9:0] e[$];
    send(1'b1, 7'h22, 8'h00, 4'h0);
    wait_rsp("read");
    e = '{10'h100, 10'h206, 10'h204, 10'h145, 10'h201, 10'h203, 10'h205};
    d = log_diff(mark, e);
    tests++;
    if (d != 0) begin fails++; $display("FAIL read_seq: %0d writes, diff %0d, required 7 writes diff 0", wlog.size() - mark, d); end
    tests++;
    if (rsp_data !== 8'h5C) begin fails++; $display("FAIL read_data: got %h, required 5c", rsp_data); end
    tests++;
    if (rsp_status !== 2'b00) begin fails++; $display("FAIL read_status: got %b, required 00", rsp_status); end
    tests++;
    if (dpr_reads - dr != 1) begin fails++; $display("FAIL read_dpr_reads: got %0d, required 1", dpr_reads - dr); end
  endtask

  task automatic test_nak();
    int mark = wlog.size();
    int d;
    logic [9:0] e[$];
    send(1'b0, 7'h10, 8'h77, 4'h0);
    wait_rsp("nak");
    e = '{10'h100, 10'h206, 10'h204, 10'h120, 10'h201, 10'h205};
    d = log_diff(mark, e);
    tests++;
    if (d != 0) begin fails++; $display("FAIL nak_seq: %0d writes, diff %0d, required 6 writes diff 0", wlog.size() - mark, d); end
    tests++;
    if (rsp_status !== 2'b01) begin fails++; $display("FAIL nak_status: got %b, required 01", rsp_status); end
    tests++;
    if (seen_data !== 8'hA5) begin fails++; $display("FAIL nak_no_data: slave data %h, required a5", seen_data); end
  endtask

  task automatic test_timeout();
    int mark = wlog.size();
    int d;
    logic [9:0] e[$];
    hang_start = 1'b1;
    send(1'b0, 7'h22, 8'h33, 4'h0);
    wait_rsp("timeout");
    e = '{10'h100, 10'h206, 10'h204};
    d = log_diff(mark, e);
    tests++;
    if (d != 0) begin fails++; $display("FAIL timeout_seq: %0d writes, diff %0d, required 3 writes diff 0", wlog.size() - mark, d); end
    tests++;
    if (cmdr_reads != 8) begin fails++; $display("FAIL timeout_polls: got %0d, required 8", cmdr_reads); end
    tests++;
    if ({rsp_status, rsp_data} !== 10'h300) begin fails++; $display("FAIL timeout_rsp: status %b data %h, required 11 00", rsp_status, rsp_data); end
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL timeout_idle: ready %b, required 1", req_ready); end
    hang_start = 1'b0;
  endtask

  task automatic test_back_to_back();
    int mark = wlog.size();
    int n = 0;
    int d;
    logic [9:0] e[$];
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 7'h22; req_data = 8'h11; req_bus = 4'h3;
    while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    wait_rsp("b2b_a");
    tests++;
    if (req_ready !== 1'b0) begin fails++; $display("FAIL b2b_resp_ready: got %b, required 0", req_ready); end
    e = '{10'h103, 10'h206, 10'h204, 10'h144, 10'h201, 10'h111, 10'h201, 10'h205};
    d = log_diff(mark, e);
    tests++;
    if (d != 0) begin fails++; $display("FAIL b2b_a_seq: %0d writes, diff %0d, required 8 writes diff 0", wlog.size() - mark, d); end
    req_rw = 1'b1; req_bus = 4'h5;
    mark = wlog.size();
    @(negedge clk);
    tests++;
    if ({rsp_valid, req_ready} !== 2'b01) begin fails++; $display("FAIL b2b_idle: valid/ready %b, required 01", {rsp_valid, req_ready}); end
    @(negedge clk);
    req_valid = 1'b0;
    tests++;
    if (req_ready !== 1'b0) begin fails++; $display("FAIL b2b_accept: ready %b, required 0", req_ready); end
    wait_rsp("b2b_b");
    tests++;
    if ({rsp_status, rsp_data} !== 10'h05C) begin fails++; $display("FAIL b2b_b_rsp: status %b data %h, required 00 5c", rsp_status, rsp_data); end
    e = '{10'h105, 10'h206, 10'h204, 10'h145, 10'h201, 10'h203, 10'h205};
    d = log_diff(mark, e);
    tests++;
    if (d != 0) begin fails++; $display("FAIL b2b_b_seq: %0d writes, diff %0d, required 7 writes diff 0", wlog.size() - mark, d); end
  endtask

  task automatic test_reset_mid();
    int mark = wlog.size();
    int rc;
    int n = 0;
    int d;
    logic [9:0] e[$];
    send(1'b0, 7'h22, 8'h99, 4'h0);
    while (!((wlog.size() - mark >= 7) && cyc === 1'b1 && we === 1'b0) && n < 2000) begin
      @(negedge clk); n++;
    end
    tests++;
    if (wlog.size() - mark < 7) begin fails++; $display("FAIL rstmid_reach_wait: %0d writes, required 7", wlog.size() - mark); end
    rc = rsp_count;
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (cyc !== 1'b0) begin fails++; $display("FAIL rstmid_cyc_drop: got %b, required 0", cyc); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    tests++;
    if (rsp_count != rc) begin fails++; $display("FAIL rstmid_no_rsp: %0d pulses, required 0", rsp_count - rc); end
    mark = wlog.size();
    send(1'b0, 7'h22, 8'h5A, 4'h0);
    wait_rsp("rstmid");
    e = '{10'h080, 10'h100, 10'h206, 10'h204, 10'h144, 10'h201, 10'h15A, 10'h201, 10'h205};
    d = log_diff(mark, e);
    tests++;
    if (d != 0) begin fails++; $display("FAIL rstmid_seq: %0d writes, diff %0d, required 9 writes diff 0", wlog.size() - mark, d); end
    tests++;
    if (rsp_status !== 2'b00) begin fails++; $display("FAIL rstmid_status: got %b, required 00", rsp_status); end
  endtask

  task automatic test_protocol();
    repeat (3) @(negedge clk);
    tests++;
    if (proto_err != 0) begin fails++; $display("FAIL wb_protocol: %0d violations, required 0", proto_err); end
    tests++;
    if (fsmr_hits != 0) begin fails++; $display("FAIL fsmr_access: %0d accesses, required 0", fsmr_hits); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nak();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
